// File: rtl/pdp8_pkg.sv
// ---------------------------------------------------------------------------
// pdp8_pkg
// Shared definitions for the PDP-8 memory subsystem: address/data widths,
// the memory arbiter's FSM state encoding and the requester (owner) encoding.
// No ports; imported with "import pdp8_pkg::*".
// ---------------------------------------------------------------------------
package pdp8_pkg;

    // 32K words of 12-bit memory: 15-bit field+address, 12-bit data.
    localparam int PDP8_AW = 15;
    localparam int PDP8_DW = 12;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

    // Which requester currently owns (or last owned) the memory.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } arb_owner_t;

    // The access-window counter counts down to zero, so it is loaded with
    // one less than the number of strobe cycles wanted.
    function automatic logic [3:0] latLoad(input int lat);
        return 4'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational requester selector for pdp8_mem_arb.
// A lone requester always wins. On a tie the requester that was NOT served
// last wins; the parent gets fixed DMA priority by tying i_last_owner to
// OWN_CPU, which makes every tie resolve to DMA.
//
// Ports:
//   i_cpu_req     CPU request
//   i_dma_req     data-break request (read or write)
//   i_last_owner  requester served most recently
//   o_grant       some requester is present
//   o_owner       requester selected for the next access
// ---------------------------------------------------------------------------
module mem_arb_pick
    import pdp8_pkg::*;
(
    input  logic       i_cpu_req,
    input  logic       i_dma_req,
    input  arb_owner_t i_last_owner,
    output logic       o_grant,
    output arb_owner_t o_owner
);

    always_comb begin
        o_grant = i_cpu_req | i_dma_req;
        o_owner = OWN_CPU;
        if (i_cpu_req && i_dma_req) begin
            o_owner = (i_last_owner == OWN_DMA) ? OWN_CPU : OWN_DMA;
        end else if (i_dma_req) begin
            o_owner = OWN_DMA;
        end
    end

endmodule

// File: rtl/pdp8_mem_arb.sv
// ---------------------------------------------------------------------------
// pdp8_mem_arb
// Two-port arbiter/sequencer for the 32Kx12 main memory. Grants the CPU port
// or the I/O data-break port, drives the RAM strobes for RAM_LAT cycles from
// latched request values, then pulses the winner's ack/done for one cycle.
//
// Configuration:
//   MEM_ARB_FAIR_EN  defined   : round-robin between CPU and DMA on ties
//                    undefined : fixed DMA priority (data-break rule)
//
// Parameters:
//   RAM_LAT          strobe cycles per access (1..15)
//
// Ports:
//   clk, reset                    clock, async active-high reset
//   cpu_req/we/addr/wdata         CPU request, direction, address, data
//   cpu_rdata, cpu_ack            CPU read data (held), completion pulse
//   dma_read_req/dma_write_req    data-break requests (write wins)
//   dma_ma, dma_wdata             data-break address and write data
//   dma_rdata, dma_done           data-break read data (held), completion
//   ram_addr/wdata/rdata          RAM address, write data, read data
//   ram_rd, ram_wr                RAM strobes
//   busy                          arbiter not idle
// ---------------------------------------------------------------------------
module pdp8_mem_arb
    import pdp8_pkg::*;
#(
    parameter int RAM_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [PDP8_AW-1:0] cpu_addr,
    input  logic [PDP8_DW-1:0] cpu_wdata,
    output logic [PDP8_DW-1:0] cpu_rdata,
    output logic               cpu_ack,
    input  logic               dma_read_req,
    input  logic               dma_write_req,
    input  logic [PDP8_AW-1:0] dma_ma,
    input  logic [PDP8_DW-1:0] dma_wdata,
    output logic [PDP8_DW-1:0] dma_rdata,
    output logic               dma_done,
    output logic [PDP8_AW-1:0] ram_addr,
    output logic [PDP8_DW-1:0] ram_wdata,
    input  logic [PDP8_DW-1:0] ram_rdata,
    output logic               ram_rd,
    output logic               ram_wr,
    output logic               busy
);

    localparam logic [3:0] LAT_LOAD = latLoad(RAM_LAT);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    arb_owner_t         r_owner;
    arb_owner_t         w_pick_owner;
    arb_owner_t         w_last_owner;
    logic               w_dma_req;
    logic               w_grant;
    logic               r_we;
    logic [3:0]         r_cnt;
    logic [PDP8_AW-1:0] r_addr;
    logic [PDP8_DW-1:0] r_wdata;
    logic [PDP8_DW-1:0] r_cpu_rdata;
    logic [PDP8_DW-1:0] r_dma_rdata;
    logic               w_sel_we;
    logic [PDP8_AW-1:0] w_sel_addr;
    logic [PDP8_DW-1:0] w_sel_wdata;

    // A data-break read and write together counts as one write request.
    assign w_dma_req = dma_read_req | dma_write_req;

    mem_arb_pick u_pick (
        .i_cpu_req    (cpu_req),
        .i_dma_req    (w_dma_req),
        .i_last_owner (w_last_owner),
        .o_grant      (w_grant),
        .o_owner      (w_pick_owner)
    );

`ifdef MEM_ARB_FAIR_EN
    arb_owner_t r_last_owner;

    // Remember who was granted last so the other side wins the next tie.
    // Starts as DMA so the CPU wins the first tie after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_owner <= OWN_DMA;
        end else if (r_state == ARB_IDLE && w_grant) begin
            r_last_owner <= w_pick_owner;
        end
    end

    assign w_last_owner = r_last_owner;
`else
    // Pretending the CPU was always served last makes every tie go to DMA.
    assign w_last_owner = OWN_CPU;
`endif

    // Steer the winning requester's direction, address and data to the
    // grant registers.
    always_comb begin
        w_sel_we    = cpu_we;
        w_sel_addr  = cpu_addr;
        w_sel_wdata = cpu_wdata;
        if (w_pick_owner == OWN_DMA) begin
            w_sel_we    = dma_write_req;
            w_sel_addr  = dma_ma;
            w_sel_wdata = dma_wdata;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic. DONE always returns to IDLE, so requests seen
    // during DONE cannot start an access.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE:   if (w_grant) w_state_nxt = ARB_ACCESS;
            ARB_ACCESS: if (r_cnt == 4'd0) w_state_nxt = ARB_DONE;
            ARB_DONE:   w_state_nxt = ARB_IDLE;
            default:    w_state_nxt = ARB_IDLE;
        endcase
    end

    // Datapath: latch the request at grant, count the access window down,
    // and on the last window cycle capture read data for the owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner     <= OWN_CPU;
            r_we        <= 1'b0;
            r_cnt       <= 4'd0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_pick_owner;
                        r_we    <= w_sel_we;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_cnt   <= LAT_LOAD;
                    end
                end
                ARB_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (!r_we) begin
                        if (r_owner == OWN_DMA) begin
                            r_dma_rdata <= ram_rdata;
                        end else begin
                            r_cpu_rdata <= ram_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM outputs: decoded purely from registers, never from inputs.
    always_comb begin
        ram_addr  = r_addr;
        ram_wdata = r_wdata;
        ram_rd    = (r_state == ARB_ACCESS) && !r_we;
        ram_wr    = (r_state == ARB_ACCESS) && r_we;
        cpu_ack   = (r_state == ARB_DONE) && (r_owner == OWN_CPU);
        dma_done  = (r_state == ARB_DONE) && (r_owner == OWN_DMA);
        busy      = (r_state != ARB_IDLE);
        cpu_rdata = r_cpu_rdata;
        dma_rdata = r_dma_rdata;
    end

endmodule

// File: tb/tb_pdp8_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_pdp8_mem_arb
// Bench for pdp8_mem_arb. Contains a behavioural 32Kx12 RAM, a reference
// model of memory contents and grant order, a table of single-requester
// vectors, hand-written contention/reset sequences and random traffic.
// ---------------------------------------------------------------------------
module tb_pdp8_mem_arb;

    localparam int RAM_LAT = 2;
`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [11:0] cpu_wdata;
    logic [11:0] cpu_rdata;
    logic        cpu_ack;
    logic        dma_read_req;
    logic        dma_write_req;
    logic [14:0] dma_ma;
    logic [11:0] dma_wdata;
    logic [11:0] dma_rdata;
    logic        dma_done;
    logic [14:0] ram_addr;
    logic [11:0] ram_wdata;
    logic [11:0] ram_rdata;
    logic        ram_rd;
    logic        ram_wr;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pdp8_mem_arb #(.RAM_LAT(RAM_LAT)) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .cpu_ack       (cpu_ack),
        .dma_read_req  (dma_read_req),
        .dma_write_req (dma_write_req),
        .dma_ma        (dma_ma),
        .dma_wdata     (dma_wdata),
        .dma_rdata     (dma_rdata),
        .dma_done      (dma_done),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .ram_rd        (ram_rd),
        .ram_wr        (ram_wr),
        .busy          (busy)
    );

    // Power-on memory contents; 01234 holds 5432 for the directed read.
    function automatic logic [11:0] initVal(input logic [14:0] a);
        return (a == 15'o01234) ? 12'o5432 : 12'(a * 15'd5 + 15'd3);
    endfunction

    // Behavioural RAM: asynchronous read, write on the clock while strobed.
    logic [11:0] mem [0:32767];
    bit          memValid [0:32767];
    assign ram_rdata = memValid[ram_addr] ? mem[ram_addr] : initVal(ram_addr);
    always @(posedge clk) begin
        if (ram_wr) begin
            mem[ram_addr]      <= ram_wdata;
            memValid[ram_addr] <= 1'b1;
        end
    end

    // Reference model state: what memory should hold and who was served last.
    logic [11:0] refMem [int];
    bit          lastDma = 1'b1;

    function automatic logic [11:0] refRead(input logic [14:0] a);
        return refMem.exists(int'(a)) ? refMem[int'(a)] : initVal(a);
    endfunction

    // One expected access, in service order.
    typedef struct {
        bit          dma;
        bit          we;
        logic [14:0] addr;
        logic [11:0] data;
        int          cyc;
    } accExp_t;
    accExp_t expQ[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Predict the service order from the arbitration rules: a lone requester
    // wins; a tie goes to DMA, or in fair mode to whoever was not served last.
    // Access k completes RAM_LAT+1 + k*(RAM_LAT+2) cycles after the request.
    task automatic predict(input bit cReq, input bit cWe, input logic [14:0] cAddr,
                           input logic [11:0] cData, input bit dRd, input bit dWr,
                           input logic [14:0] dAddr, input logic [11:0] dData,
                           input bit hold, input int nAcc);
        bit cPend = cReq;
        bit dPend = dRd | dWr;
        int k = 0;
        accExp_t e;
        while ((cPend || dPend) && (!hold || k < nAcc)) begin
            if (cPend && dPend) e.dma = FAIR ? !lastDma : 1'b1;
            else                e.dma = dPend;
            e.we   = e.dma ? dWr : cWe;
            e.addr = e.dma ? dAddr : cAddr;
            e.data = e.we ? (e.dma ? dData : cData) : refRead(e.addr);
            if (e.we) refMem[int'(e.addr)] = e.data;
            e.cyc  = RAM_LAT + 1 + k * (RAM_LAT + 2);
            expQ.push_back(e);
            lastDma = e.dma;
            if (!hold) begin
                if (e.dma) dPend = 1'b0;
                else       cPend = 1'b0;
            end
            k++;
        end
    endtask

    // Drive the requests and follow the DUT through every expected access,
    // checking strobes, completion order/timing and read data.
    task automatic applyStimulus(input bit cReq, input bit cWe, input logic [14:0] cAddr,
                                 input logic [11:0] cData, input bit dRd, input bit dWr,
                                 input logic [14:0] dAddr, input logic [11:0] dData,
                                 input bit hold);
        int cyc = 0;
        int strobes = 0;
        int spurious = 0;
        int budget = expQ.size() * (RAM_LAT + 2) + 10;
        @(negedge clk);
        cpu_req = cReq; cpu_we = cWe; cpu_addr = cAddr; cpu_wdata = cData;
        dma_read_req = dRd; dma_write_req = dWr; dma_ma = dAddr; dma_wdata = dData;
        while (expQ.size() > 0 && cyc < budget) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (ram_rd || ram_wr) begin
                strobes++;
                checkOutput("strobeAddr", 32'(ram_addr), 32'(expQ[0].addr));
                checkOutput("strobeDir", {30'd0, ram_wr, ram_rd}, expQ[0].we ? 32'd2 : 32'd1);
                if (expQ[0].we) checkOutput("strobeWdata", 32'(ram_wdata), 32'(expQ[0].data));
            end
            if (cpu_ack || dma_done) begin
                checkOutput("ackOwner", {30'd0, cpu_ack, dma_done}, expQ[0].dma ? 32'd1 : 32'd2);
                checkOutput("ackCycle", 32'(cyc), 32'(expQ[0].cyc));
                checkOutput("strobeCount", 32'(strobes), 32'(RAM_LAT));
                if (!expQ[0].we)
                    checkOutput("readData", 32'(expQ[0].dma ? dma_rdata : cpu_rdata), 32'(expQ[0].data));
                if (!hold) begin
                    if (cpu_ack) cpu_req = 1'b0;
                    if (dma_done) begin dma_read_req = 1'b0; dma_write_req = 1'b0; end
                end
                strobes = 0;
                void'(expQ.pop_front());
            end
        end
        if (expQ.size() > 0) begin
            checkOutput("timeout", 32'(expQ.size()), 32'd0);
            expQ.delete();
        end
        cpu_req = 1'b0; dma_read_req = 1'b0; dma_write_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ack || dma_done || ram_rd || ram_wr) spurious++;
        end
        checkOutput("quietAfter", 32'(spurious), 32'd0);
    endtask

    // Model first, then drive: the usual way to run one scenario.
    task automatic runCase(input bit cReq, input bit cWe, input logic [14:0] cAddr,
                           input logic [11:0] cData, input bit dRd, input bit dWr,
                           input logic [14:0] dAddr, input logic [11:0] dData,
                           input bit hold, input int nAcc);
        predict(cReq, cWe, cAddr, cData, dRd, dWr, dAddr, dData, hold, nAcc);
        applyStimulus(cReq, cWe, cAddr, cData, dRd, dWr, dAddr, dData, hold);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        lastDma = 1'b1;
    endtask

    // Single-requester vectors with their expected access.
    typedef struct {
        bit          cReq;
        bit          cWe;
        logic [14:0] cAddr;
        logic [11:0] cData;
        bit          dRd;
        bit          dWr;
        logic [14:0] dAddr;
        logic [11:0] dData;
        bit          expDma;
        bit          expWe;
        logic [14:0] expAddr;
        logic [11:0] expData;
    } vec_t;

    function automatic vec_t mkVec(input bit cReq, input bit cWe, input logic [14:0] cAddr,
                                   input logic [11:0] cData, input bit dRd, input bit dWr,
                                   input logic [14:0] dAddr, input logic [11:0] dData,
                                   input bit expDma, input bit expWe,
                                   input logic [14:0] expAddr, input logic [11:0] expData);
        vec_t v;
        v.cReq = cReq; v.cWe = cWe; v.cAddr = cAddr; v.cData = cData;
        v.dRd = dRd; v.dWr = dWr; v.dAddr = dAddr; v.dData = dData;
        v.expDma = expDma; v.expWe = expWe; v.expAddr = expAddr; v.expData = expData;
        return v;
    endfunction

    initial begin
        vec_t    vecs [7];
        accExp_t e;
        int      ackSeen;

        vecs[0] = mkVec(1, 0, 15'o01234, 12'o0000, 0, 0, 15'o00000, 12'o0000, 0, 0, 15'o01234, 12'o5432);
        vecs[1] = mkVec(0, 0, 15'o00000, 12'o0000, 0, 1, 15'o77777, 12'o7777, 1, 1, 15'o77777, 12'o7777);
        vecs[2] = mkVec(1, 0, 15'o77777, 12'o0000, 0, 0, 15'o00000, 12'o0000, 0, 0, 15'o77777, 12'o7777);
        vecs[3] = mkVec(0, 0, 15'o00000, 12'o0000, 1, 1, 15'o00010, 12'o1234, 1, 1, 15'o00010, 12'o1234);
        vecs[4] = mkVec(1, 0, 15'o00010, 12'o0000, 0, 0, 15'o00000, 12'o0000, 0, 0, 15'o00010, 12'o1234);
        vecs[5] = mkVec(1, 1, 15'o00123, 12'o4321, 0, 0, 15'o00000, 12'o0000, 0, 1, 15'o00123, 12'o4321);
        vecs[6] = mkVec(0, 1, 15'o00000, 12'o0000, 1, 0, 15'o00123, 12'o0000, 1, 0, 15'o00123, 12'o4321);

        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_read_req = 1'b0; dma_write_req = 1'b0; dma_ma = '0; dma_wdata = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("resetCtl", {27'd0, busy, cpu_ack, dma_done, ram_rd, ram_wr}, 32'd0);
        checkOutput("resetBus", {5'd0, ram_addr, ram_wdata}, 32'd0);
        checkOutput("resetRdata", {8'd0, cpu_rdata, dma_rdata}, 32'd0);
        reset = 1'b0;

        // Directed single-requester vectors.
        for (int i = 0; i < 7; i++) begin
            e.dma  = vecs[i].expDma;
            e.we   = vecs[i].expWe;
            e.addr = vecs[i].expAddr;
            e.data = vecs[i].expData;
            e.cyc  = RAM_LAT + 1;
            expQ.push_back(e);
            if (e.we) refMem[int'(e.addr)] = e.data;
            lastDma = e.dma;
            applyStimulus(vecs[i].cReq, vecs[i].cWe, vecs[i].cAddr, vecs[i].cData,
                          vecs[i].dRd, vecs[i].dWr, vecs[i].dAddr, vecs[i].dData, 1'b0);
        end

        // Simultaneous CPU read 00200 and DMA read 00300 straight after reset.
        doReset();
        runCase(1, 0, 15'o00200, 12'o0000, 1, 0, 15'o00300, 12'o0000, 1'b0, 0);

        // Continuous contention over 8 accesses.
        doReset();
        runCase(1, 0, 15'o00200, 12'o0000, 1, 0, 15'o00300, 12'o0000, 1'b1, 8);

        // Reset during the second ACCESS cycle of a CPU write.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'o05555; cpu_wdata = 12'o1111;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("preResetWr", {31'd0, ram_wr}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abortCtl", {27'd0, busy, cpu_ack, dma_done, ram_rd, ram_wr}, 32'd0);
        checkOutput("abortBus", {5'd0, ram_addr, ram_wdata}, 32'd0);
        checkOutput("abortRdata", {8'd0, cpu_rdata, dma_rdata}, 32'd0);
        cpu_req = 1'b0;
        ackSeen = 0;
        repeat (2) begin
            @(negedge clk);
            if (cpu_ack) ackSeen++;
        end
        reset = 1'b0;
        lastDma = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (cpu_ack) ackSeen++;
        end
        checkOutput("noAckAfterAbort", 32'(ackSeen), 32'd0);
        runCase(1, 0, 15'o01234, 12'o0000, 0, 0, 15'o00000, 12'o0000, 1'b0, 0);

        // Random traffic over a small address pool so reads hit earlier writes.
        for (int n = 0; n < 30; n++) begin
            int          scen;
            bit          cR, cW, dR, dW;
            logic [14:0] cA, dA;
            logic [11:0] cD, dD;
            scen = int'($urandom_range(0, 2));
            cR = (scen != 1);
            cW = 1'($urandom_range(0, 1));
            dW = (scen != 0) && 1'($urandom_range(0, 1));
            dR = (scen != 0) && (!dW || 1'($urandom_range(0, 1)));
            cA = 15'o40000 | 15'($urandom_range(0, 7));
            dA = 15'o40000 | 15'($urandom_range(0, 7));
            cD = 12'($urandom);
            dD = 12'($urandom);
            runCase(cR, cW, cA, cD, dR, dW, dA, dD, 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
